fifo_rr_sched: RTL and testbench
================================

FIFO_RR_SCHED -- requirements
Module: fifo_rr_sched

Interface
REQ-001 SHALL have parameter WORD_W, default 8, meaning data word width.
REQ-002 SHALL have parameter INIT_CYCLES, default 4, meaning cycles spent in INIT after reset release.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_wr  input  1  upstream has a word for the lane FIFOs.
REQ-006 SHALL have ports almost_full_f1, almost_full_f2  input  1 each  lane FIFO almost-full flags.
REQ-007 SHALL have ports empty_f1, empty_f2  input  1 each  lane FIFO empty flags.
REQ-008 SHALL have port down_almost_full  input  1  downstream backpressure.
REQ-009 SHALL have ports out1, out2  input  WORD_W each  lane FIFO read data, valid one cycle after read.
REQ-010 SHALL have port write  output  1  write enable to lane FIFOs.
REQ-011 SHALL have ports read1, read2  output  1 each  read pulses to lane FIFOs.
REQ-012 SHALL have port data_out  output  WORD_W  scheduled word.
REQ-013 SHALL have port valid_out  output  1  data_out valid.
REQ-014 SHALL have port state  output  3  current FSM state encoding.
REQ-015 SHALL have port idle  output  1  high when state is IDLE.

Function
REQ-016 SHALL implement FSM states RESET=0, INIT=1, IDLE=2, ACTIVE=3, PAUSE=4.
REQ-017 SHALL go RESET->INIT on the first edge after reset deasserts; INIT->IDLE after exactly INIT_CYCLES cycles in INIT (counter 0..INIT_CYCLES-1).
REQ-018 SHALL go IDLE->ACTIVE when either empty_fX is low; ACTIVE->IDLE when both empty flags high and no read issued this cycle.
REQ-019 SHALL go ACTIVE->PAUSE when down_almost_full high (priority over ACTIVE->IDLE); PAUSE->ACTIVE when down_almost_full low.
REQ-020 SHALL register write=1 one cycle after sampling req_wr=1 with both almost_full flags low in IDLE, ACTIVE or PAUSE; otherwise write=0.
REQ-021 SHALL, in ACTIVE with down_almost_full low, assert at most one of read1/read2 per cycle (registered, latency 1 from flags).
REQ-022 SHALL grant round-robin: prefer the lane not granted last; if the preferred lane is empty grant the other; if both empty grant none.
REQ-023 SHALL update the last-grant pointer only when a grant is issued; pointer resets to lane 2 so the first grant goes to lane 1.
REQ-024 SHALL capture out1 or out2 into data_out and assert valid_out exactly one cycle after the corresponding readX pulse, using a registered select.
REQ-025 SHALL complete a read already issued when entering PAUSE (valid_out still asserted next cycle) and issue no new reads in PAUSE, INIT, RESET, IDLE.
REQ-026 SHALL hold data_out at its last value when valid_out is low.
REQ-027 SHALL never assert readX while empty_fX is high in the sampled cycle.

Reset
REQ-028 SHALL, while reset is low, force state=RESET, write=0, read1=0, read2=0, valid_out=0, data_out=0, idle=0, init counter=0, last-grant=lane 2.
REQ-029 SHALL abandon any in-flight read on reset mid-operation (valid_out=0 on the cycle after release).

Structure
REQ-030 SHALL take FSM state encodings and the default WORD_W from a shared package/include file used by the lane FIFO and dispatcher blocks.
REQ-031 SHALL contain one sub-module rr_arb2 (two-requester round-robin arbiter with pointer register); FSM and datapath stay in fifo_rr_sched.

Verification
REQ-032 SHALL test reset then release: state sequence 0,1,1,1,1,2 with INIT_CYCLES=4; all outputs 0 during reset.
REQ-033 SHALL test both lanes non-empty, out1=8'hA1, out2=8'hB2 -> reads alternate read1,read2,read1; data_out A1,B2,A1 each one cycle after its read.
REQ-034 SHALL test empty_f1=1, empty_f2=0 for 3 cycles -> read2 on 3 consecutive cycles, read1 never.
REQ-035 SHALL test down_almost_full rising during a read1 -> valid_out still 1 next cycle, state=4, no reads until flag drops, then state=3.
REQ-036 SHALL test req_wr=1 with almost_full_f2=1 -> write stays 0; drop flag -> write=1 next cycle.
REQ-037 SHALL test reset asserted one cycle after read2 -> valid_out=0, data_out=0, state=0 immediately.

Source files
------------

// File: rtl/fifo_rr_sched_pkg.sv
// Shared definitions for the lane FIFO scheduler: FSM state encoding and default word width.
package fifo_rr_sched_pkg;

    localparam int unsigned DefWordW = 8;

    typedef enum logic [2:0] {
        StReset  = 3'd0,
        StInit   = 3'd1,
        StIdle   = 3'd2,
        StActive = 3'd3,
        StPause  = 3'd4
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the lane granted last loses a tie on the next grant.
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic req1,
    input  logic req2,
    output logic gnt1,
    output logic gnt2
);

    // High when lane 2 received the most recent grant.
    logic last2_q;

    assign gnt1 = en && req1 && (last2_q || !req2);
    assign gnt2 = en && req2 && (!last2_q || !req1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last2_q <= 1'b1;
        end else if (gnt1 || gnt2) begin
            last2_q <= gnt2;
        end
    end

endmodule

// File: rtl/fifo_rr_sched.sv
// Round-robin read scheduler for two lane FIFOs, with init sequencing and downstream pause.
module fifo_rr_sched
    import fifo_rr_sched_pkg::*;
#(
    parameter int unsigned WORD_W      = DefWordW,
    parameter int unsigned INIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_wr,
    input  logic              almost_full_f1,
    input  logic              almost_full_f2,
    input  logic              empty_f1,
    input  logic              empty_f2,
    input  logic              down_almost_full,
    input  logic [WORD_W-1:0] out1,
    input  logic [WORD_W-1:0] out2,
    output logic              write,
    output logic              read1,
    output logic              read2,
    output logic [WORD_W-1:0] data_out,
    output logic              valid_out,
    output logic [2:0]        state,
    output logic              idle
);

    localparam int unsigned CntW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              read1_q, read2_q;
    logic              valid_q, sel2_q;
    logic [WORD_W-1:0] hold_q, data_mux;
    logic              arb_en, gnt1, gnt2;

    assign arb_en = (state_q == StActive) && !down_almost_full;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (arb_en),
        .req1  (!empty_f1),
        .req2  (!empty_f2),
        .gnt1  (gnt1),
        .gnt2  (gnt2)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StReset: state_d = StInit;
            StInit: begin
                if (cnt_q == CntW'(INIT_CYCLES - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StIdle: begin
                if (!empty_f1 || !empty_f2) state_d = StActive;
            end
            StActive: begin
                // A read still on the wire keeps us ACTIVE so its data is collected.
                if (down_almost_full) begin
                    state_d = StPause;
                end else if (empty_f1 && empty_f2 && !read1_q && !read2_q) begin
                    state_d = StIdle;
                end
            end
            StPause: begin
                if (!down_almost_full) state_d = StActive;
            end
            default: state_d = StReset;
        endcase
    end

    assign write_d = req_wr && !almost_full_f1 && !almost_full_f2 &&
                     (state_q inside {StIdle, StActive, StPause});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StReset;
            cnt_q   <= '0;
            write_q <= 1'b0;
            read1_q <= 1'b0;
            read2_q <= 1'b0;
            valid_q <= 1'b0;
            sel2_q  <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            read1_q <= gnt1;
            read2_q <= gnt2;
            valid_q <= read1_q || read2_q;
            sel2_q  <= read2_q;
            if (valid_q) hold_q <= data_mux;
        end
    end

    // Lane data is valid the cycle after its read pulse, so select it live and hold afterwards.
    assign data_mux  = sel2_q ? out2 : out1;
    assign data_out  = valid_q ? data_mux : hold_q;
    assign valid_out = valid_q;
    assign write     = write_q;
    assign read1     = read1_q;
    assign read2     = read2_q;
    assign state     = state_q;
    assign idle      = (state_q == StIdle);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// Self-checking bench for fifo_rr_sched: directed scenarios plus randomized run against a lane-level model.
module tb_fifo_rr_sched;

    localparam int W      = 8;
    localparam int INIT_N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_wr = 1'b0, af1 = 1'b0, af2 = 1'b0;
    logic         e1 = 1'b1, e2 = 1'b1, daf = 1'b0;
    logic [W-1:0] out1 = '0, out2 = '0;
    logic         write, read1, read2, valid_out, idle;
    logic [W-1:0] data_out;
    logic [2:0]   state;

    int checks = 0;
    int failures = 0;

    // Model: state number, cycles spent in INIT, last granted lane, lane being read now,
    // lane whose data is presented now (0 = none), held output word.
    int           m_st, m_cnt, m_last, m_rd, m_vlane;
    bit           m_wr;
    logic [W-1:0] m_hold;

    fifo_rr_sched #(.WORD_W(W), .INIT_CYCLES(INIT_N)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_wr           (req_wr),
        .almost_full_f1   (af1),
        .almost_full_f2   (af2),
        .empty_f1         (e1),
        .empty_f2         (e2),
        .down_almost_full (daf),
        .out1             (out1),
        .out2             (out2),
        .write            (write),
        .read1            (read1),
        .read2            (read2),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .state            (state),
        .idle             (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lane_empty(input int lane);
        return (lane == 1) ? e1 : e2;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_last = 2; m_rd = 0; m_vlane = 0; m_wr = 0; m_hold = '0;
    endtask

    task automatic model_step();
        int g, pref, nst;
        if (m_vlane == 1) m_hold = out1;
        else if (m_vlane == 2) m_hold = out2;
        g = 0;
        if (m_st == 3 && !daf) begin
            pref = (m_last == 2) ? 1 : 2;
            if (!lane_empty(pref)) g = pref;
            else if (!lane_empty(3 - pref)) g = 3 - pref;
        end
        if (g != 0) m_last = g;
        nst = m_st;
        case (m_st)
            0: nst = 1;
            1: begin
                m_cnt++;
                if (m_cnt == INIT_N) begin nst = 2; m_cnt = 0; end
            end
            2: if (!e1 || !e2) nst = 3;
            3: if (daf) nst = 4; else if (e1 && e2 && m_rd == 0) nst = 2;
            4: if (!daf) nst = 3;
            default: nst = 0;
        endcase
        m_wr    = req_wr && !af1 && !af2 && (m_st >= 2);
        m_vlane = m_rd;
        m_rd    = g;
        m_st    = nst;
    endtask

    task automatic compare_all();
        logic [W-1:0] exp_data;
        exp_data = (m_vlane == 1) ? out1 : (m_vlane == 2) ? out2 : m_hold;
        check("state", 32'(state), 32'(m_st));
        check("idle", 32'(idle), 32'(m_st == 2));
        check("write", 32'(write), 32'(m_wr));
        check("read1", 32'(read1), 32'(m_rd == 1));
        check("read2", 32'(read2), 32'(m_rd == 2));
        check("valid_out", 32'(valid_out), 32'(m_vlane != 0));
        check("data_out", 32'(data_out), 32'(exp_data));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        int seq [5];
        seq = '{1, 1, 1, 1, 2};

        // Reset and init sequence
        #2;
        apply_reset();
        check("rst_state", 32'(state), 32'd0);
        check("rst_outs", 32'({write, read1, read2, valid_out, idle}), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
        repeat (2) cycle();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("init_seq", 32'(state), 32'(seq[i]));
        end

        // Both lanes busy: alternating grants starting at lane 1
        e1 = 1'b0; e2 = 1'b0; out1 = 8'hA1; out2 = 8'hB2;
        cycle();
        check("to_active", 32'(state), 32'd3);
        cycle();
        check("rr_r1_a", 32'({read1, read2}), 32'b10);
        cycle();
        check("rr_r2", 32'({read1, read2}), 32'b01);
        check("rr_d_a1", 32'({valid_out, data_out}), 32'h1A1);
        cycle();
        check("rr_r1_b", 32'({read1, read2}), 32'b10);
        check("rr_d_b2", 32'({valid_out, data_out}), 32'h1B2);
        cycle();
        check("rr_d_a1b", 32'({valid_out, data_out}), 32'h1A1);

        // Only lane 2 non-empty
        e1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("lane2_only", 32'({read1, read2}), 32'b01);
        end

        // Pause while a lane-1 read is in flight
        e1 = 1'b0; out1 = 8'h5C;
        cycle();
        check("pre_pause_r1", 32'({read1, read2}), 32'b10);
        daf = 1'b1;
        cycle();
        check("pause_state", 32'(state), 32'd4);
        check("pause_valid", 32'({valid_out, data_out}), 32'h15C);
        check("pause_noread", 32'({read1, read2}), 32'b00);
        repeat (2) begin
            cycle();
            check("pause_hold", 32'({state, read1, read2}), 32'b10000);
        end
        daf = 1'b0;
        cycle();
        check("unpause", 32'(state), 32'd3);

        // Write gating by almost-full
        req_wr = 1'b1; af2 = 1'b1;
        cycle();
        check("wr_blocked", 32'(write), 32'd0);
        af2 = 1'b0;
        cycle();
        check("wr_ok", 32'(write), 32'd1);
        req_wr = 1'b0;

        // Reset one cycle after a lane-2 read
        e1 = 1'b1; e2 = 1'b0;
        cycle();
        check("pre_rst_r2", 32'(read2), 32'd1);
        cycle();
        check("pre_rst_valid", 32'(valid_out), 32'd1);
        apply_reset();
        check("mid_rst", 32'({state, valid_out}), 32'd0);
        check("mid_rst_data", 32'(data_out), 32'd0);
        cycle();
        reset = 1'b1;
        cycle();
        check("post_rst", 32'({state, valid_out}), 32'b0010);

        // Randomized run
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
                repeat ($urandom_range(1, 3)) cycle();
                reset = 1'b1;
            end
            e1     = ($urandom_range(0, 2) == 0);
            e2     = ($urandom_range(0, 2) == 0);
            daf    = ($urandom_range(0, 4) == 0);
            req_wr = $urandom_range(0, 1) == 1;
            af1    = ($urandom_range(0, 6) == 0);
            af2    = ($urandom_range(0, 6) == 0);
            out1   = W'($urandom);
            out2   = W'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
